// File: rtl/game_flow_controller_pkg.sv
// Shared constants for the game-flow sequencer: state encodings, default
// timing/lives values and the life-LED thermometer helper.
package game_flow_controller_pkg;

  // Kept distinct from the older two-state IDLE/RUNNING localparams.
  typedef enum logic [1:0] {
    GF_IDLE    = 2'd0,
    GF_RUNNING = 2'd1,
    GF_HIT     = 2'd2,
    GF_OVER    = 2'd3
  } gf_state_t;

  localparam int C_LIVES_INI_DEF    = 3;
  localparam int C_LIVES_MAX_DEF    = 3;
  localparam int C_HIT_FRAMES_DEF   = 60;
  localparam int C_OVER_FRAMES_DEF  = 180;
  localparam int C_BLINK_FRAMES_DEF = 15;

  // Thermometer code for the life LEDs, bit0 = first life.
  function automatic logic [2:0] lives_therm(input logic [1:0] lives);
    logic [2:0] t;
    case (lives)
      2'd0:    t = 3'b000;
      2'd1:    t = 3'b001;
      2'd2:    t = 3'b011;
      default: t = 3'b111;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Signal bundle between the game logic (collisions, VGA timing, switches)
// and the game-flow sequencer. The sequencer is the slave side.
interface game_flow_controller_if;
  logic       frame_tick;    // one pulse per frame
  logic       all_switch;    // debounced AND of all switches
  logic       has_collided;  // collision level
  logic       level_up;      // one pulse when the goal is reached
  logic       game_active;   // high only while running
  logic       respawn;       // one pulse per life lost
  logic [1:0] state;         // IDLE=0 RUNNING=1 HIT=2 OVER=3
  logic [1:0] lives;
  logic [2:0] life_leds;     // bit0 drives LED_4

  modport master (
    output frame_tick, all_switch, has_collided, level_up,
    input  game_active, respawn, state, lives, life_leds
  );

  modport slave (
    input  frame_tick, all_switch, has_collided, level_up,
    output game_active, respawn, state, lives, life_leds
  );
endinterface

// File: rtl/game_flow_controller_frame_timer.sv
// 8-bit frame-tick counter. Held at zero while disabled; done pulses on the
// tick that completes lim ticks, and the count returns to zero with it.
module game_flow_controller_frame_timer (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       en,
  input  logic       tick,
  input  logic [7:0] lim,
  output logic       done
);

  logic [7:0] cnt;

  assign done = en && tick && (cnt == lim - 8'd1);

  // Count ticks while enabled; clearing on disable gives a fresh count on entry.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)   cnt <= 8'd0;
    else if (!en)   cnt <= 8'd0;
    else if (done)  cnt <= 8'd0;
    else if (tick)  cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/game_flow_controller.sv
// Game-flow sequencer: IDLE -> RUNNING -> HIT (frozen respawn pause) or
// OVER (blinking LEDs) -> IDLE. Drives game-active for the frog controller
// and the life LEDs. All outputs are registered.
module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter int C_LIVES_INI    = C_LIVES_INI_DEF,
  parameter int C_LIVES_MAX    = C_LIVES_MAX_DEF,
  parameter int C_HIT_FRAMES   = C_HIT_FRAMES_DEF,
  parameter int C_OVER_FRAMES  = C_OVER_FRAMES_DEF,
  parameter int C_BLINK_FRAMES = C_BLINK_FRAMES_DEF
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  game_flow_controller_if.slave  bus
);

  localparam logic [7:0] HIT_LIM   = 8'(C_HIT_FRAMES);
  localparam logic [7:0] OVER_LIM  = 8'(C_OVER_FRAMES);
  localparam logic [7:0] BLINK_LIM = 8'(C_BLINK_FRAMES);
  localparam logic [1:0] LIVES_INI = 2'(C_LIVES_INI);
  localparam logic [1:0] LIVES_MAX = 2'(C_LIVES_MAX);

  gf_state_t  state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic       phase_q, phase_d;
  logic       respawn_q, respawn_d;
  logic       active_q;
  logic [2:0] leds_q, leds_d;
  logic       sw_q, col_q;
  logic       start, hit;
  logic       dur_en, dur_done, blink_en, blink_done;
  logic [7:0] dur_lim;

  assign start = bus.all_switch & ~sw_q;
  assign hit   = bus.has_collided & ~col_q;

  // Edge registers run in every state; switch starts high so a switch held
  // through reset cannot start a game.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sw_q  <= 1'b1;
      col_q <= 1'b0;
    end else begin
      sw_q  <= bus.all_switch;
      col_q <= bus.has_collided;
    end
  end

  assign dur_en   = (state_q == GF_HIT) || (state_q == GF_OVER);
  assign dur_lim  = (state_q == GF_HIT) ? HIT_LIM : OVER_LIM;
  assign blink_en = (state_q == GF_OVER);

  game_flow_controller_frame_timer u_dur (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .en     (dur_en),
    .tick   (bus.frame_tick),
    .lim    (dur_lim),
    .done   (dur_done)
  );

  game_flow_controller_frame_timer u_blink (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .en     (blink_en),
    .tick   (bus.frame_tick),
    .lim    (BLINK_LIM),
    .done   (blink_done)
  );

  // State and output registers, all loaded from next-state values.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= GF_IDLE;
      lives_q   <= 2'd0;
      phase_q   <= 1'b0;
      respawn_q <= 1'b0;
      active_q  <= 1'b0;
      leds_q    <= 3'b000;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      phase_q   <= phase_d;
      respawn_q <= respawn_d;
      active_q  <= (state_d == GF_RUNNING);
      leds_q    <= leds_d;
    end
  end

  // Next state, lives and blink phase; hit beats a same-cycle level-up.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    phase_d   = 1'b0;
    respawn_d = 1'b0;
    case (state_q)
      GF_IDLE: begin
        if (start) begin
          lives_d = LIVES_INI;
          state_d = GF_RUNNING;
        end
      end
      GF_RUNNING: begin
        if (hit) begin
          respawn_d = 1'b1;
          lives_d   = lives_q - 2'd1;
          state_d   = (lives_q == 2'd1) ? GF_OVER : GF_HIT;
        end else if (bus.level_up && (lives_q < LIVES_MAX)) begin
          lives_d = lives_q + 2'd1;
        end
      end
      GF_HIT: begin
        if (dur_done) state_d = GF_RUNNING;
      end
      GF_OVER: begin
        phase_d = phase_q ^ blink_done;
        if (dur_done) state_d = GF_IDLE;
      end
      default: state_d = GF_IDLE;
    endcase
    leds_d = (state_d == GF_OVER) ? {3{phase_d}} : lives_therm(lives_d);
  end

  assign bus.game_active = active_q;
  assign bus.respawn     = respawn_q;
  assign bus.state       = state_q;
  assign bus.lives       = lives_q;
  assign bus.life_leds   = leds_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with a tick/counting reference
// model checked every cycle, plus hand-computed literal checks.
module tb_game_flow_controller;

  localparam int INI = 3, MAXL = 3, HITF = 60, OVERF = 180, BLINKF = 15;

  logic i_Clk = 1'b0;
  logic i_Rst_L;
  game_flow_controller_if bus();

  game_flow_controller dut (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .bus    (bus)
  );

  always #5 i_Clk = ~i_Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts ticks seen in the current phase.
  int m_st = 0, m_lives = 0, m_n = 0;
  bit m_resp = 0, p_sw = 1, p_col = 0, m_start, m_hit;

  always @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      m_st = 0; m_lives = 0; m_n = 0; m_resp = 0; p_sw = 1; p_col = 0;
    end else begin
      m_start = bus.all_switch && !p_sw;
      m_hit   = bus.has_collided && !p_col;
      m_resp  = 0;
      case (m_st)
        0: if (m_start) begin m_st = 1; m_lives = INI; end
        1: begin
          if (m_hit) begin
            m_resp = 1; m_lives = m_lives - 1; m_n = 0;
            m_st = (m_lives == 0) ? 3 : 2;
          end else if (bus.level_up) begin
            m_lives = (m_lives + 1 > MAXL) ? MAXL : m_lives + 1;
          end
        end
        2: if (bus.frame_tick) begin m_n++; if (m_n == HITF) m_st = 1; end
        default: if (bus.frame_tick) begin m_n++; if (m_n == OVERF) m_st = 0; end
      endcase
      p_sw  = bus.all_switch;
      p_col = bus.has_collided;
    end
  end

  function automatic int exp_leds();
    if (m_st == 3) return ((m_n / BLINKF) % 2) ? 7 : 0;
    return (1 << m_lives) - 1;
  endfunction

  // Every-cycle comparison against the model, after outputs settle.
  always @(posedge i_Clk) begin
    #2;
    chk("m_state",  int'(bus.state),       m_st);
    chk("m_lives",  int'(bus.lives),       m_lives);
    chk("m_leds",   int'(bus.life_leds),   exp_leds());
    chk("m_active", int'(bus.game_active), (m_st == 1) ? 1 : 0);
    chk("m_resp",   int'(bus.respawn),     int'(m_resp));
  end

  bit tick_en = 0;
  int tick_cnt = 0, div = 0;

  // Drive this cycle's tick, then advance to the next falling edge.
  task automatic clk_cyc();
    bus.frame_tick = tick_en && (div == 0);
    if (bus.frame_tick) tick_cnt++;
    div = (div + 1) % 3;
    @(negedge i_Clk);
  endtask

  task automatic wait_leave(input int st, input string name);
    int g = 0;
    while (int'(bus.state) == st && g < 3000) begin clk_cyc(); g++; end
    if (g >= 3000) chk({name, "_timeout"}, int'(bus.state), -1);
  endtask

  int first_on;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    i_Rst_L = 1'b0;
    bus.all_switch = 1; bus.has_collided = 0; bus.level_up = 0; bus.frame_tick = 0;
    repeat (3) @(negedge i_Clk);
    i_Rst_L = 1'b1;
    repeat (4) clk_cyc();
    chk("held_sw_idle", int'(bus.state), 0);
    chk("held_sw_leds", int'(bus.life_leds), 0);

    // Game start
    bus.all_switch = 0; clk_cyc();
    bus.all_switch = 1; clk_cyc();
    chk("start_state",  int'(bus.state), 1);
    chk("start_lives",  int'(bus.lives), 3);
    chk("start_leds",   int'(bus.life_leds), 7);
    chk("start_active", int'(bus.game_active), 1);

    // Non-fatal hit
    bus.has_collided = 1; clk_cyc();
    chk("hit_resp",  int'(bus.respawn), 1);
    chk("hit_lives", int'(bus.lives), 2);
    chk("hit_leds",  int'(bus.life_leds), 3);
    chk("hit_state", int'(bus.state), 2);
    clk_cyc();
    chk("hit_resp_end", int'(bus.respawn), 0);
    bus.has_collided = 0;
    tick_en = 1; tick_cnt = 0;
    clk_cyc();
    bus.has_collided = 1; clk_cyc();
    bus.has_collided = 0; clk_cyc();
    chk("hit_ignored_lives", int'(bus.lives), 2);
    wait_leave(2, "hit1");
    chk("hit_ticks", tick_cnt, HITF);
    chk("hit_back_state", int'(bus.state), 1);
    tick_en = 0;

    // Bonus lives
    bus.level_up = 1; clk_cyc(); bus.level_up = 0;
    chk("bonus_lives", int'(bus.lives), 3);
    bus.level_up = 1; clk_cyc(); bus.level_up = 0;
    chk("bonus_cap", int'(bus.lives), 3);

    // Back to 2 lives
    bus.has_collided = 1; clk_cyc(); bus.has_collided = 0;
    chk("hit2_lives", int'(bus.lives), 2);
    tick_en = 1; wait_leave(2, "hit2"); tick_en = 0;

    // Same-cycle hit and level-up
    bus.has_collided = 1; bus.level_up = 1; clk_cyc();
    bus.has_collided = 0; bus.level_up = 0;
    chk("same_lives", int'(bus.lives), 1);
    chk("same_state", int'(bus.state), 2);
    tick_en = 1; wait_leave(2, "hit3"); tick_en = 0;

    // Fatal hit, blink, start edges ignored
    bus.has_collided = 1; clk_cyc(); bus.has_collided = 0;
    chk("over_state", int'(bus.state), 3);
    chk("over_lives", int'(bus.lives), 0);
    chk("over_resp",  int'(bus.respawn), 1);
    chk("over_leds0", int'(bus.life_leds), 0);
    tick_en = 1; tick_cnt = 0; first_on = -1;
    begin
      int g = 0;
      while (int'(bus.state) == 3 && g < 3000) begin
        bus.all_switch = ~bus.all_switch;
        clk_cyc(); g++;
        if (first_on < 0 && bus.life_leds == 3'b111) first_on = tick_cnt;
      end
      if (g >= 3000) chk("over_timeout", int'(bus.state), -1);
    end
    bus.all_switch = 0; tick_en = 0;
    chk("blink_first_on", first_on, BLINKF);
    chk("over_ticks", tick_cnt, OVERF);
    chk("over_to_idle", int'(bus.state), 0);
    clk_cyc();
    chk("idle_after_over", int'(bus.state), 0);

    // Restart and get to lives=2 in RUNNING
    bus.all_switch = 1; clk_cyc();
    chk("restart_lives", int'(bus.lives), 3);
    bus.has_collided = 1; clk_cyc(); bus.has_collided = 0;
    tick_en = 1; wait_leave(2, "hit4"); tick_en = 0;
    chk("pre_rst_lives", int'(bus.lives), 2);

    // Asynchronous reset mid-cycle
    @(posedge i_Clk); #3;
    i_Rst_L = 1'b0;
    #1;
    chk("rst_state",  int'(bus.state), 0);
    chk("rst_lives",  int'(bus.lives), 0);
    chk("rst_leds",   int'(bus.life_leds), 0);
    chk("rst_active", int'(bus.game_active), 0);
    chk("rst_resp",   int'(bus.respawn), 0);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    repeat (5) clk_cyc();
    chk("rst_held_sw_idle", int'(bus.state), 0);
    bus.all_switch = 0; clk_cyc();
    bus.all_switch = 1; clk_cyc();
    chk("rst_restart_state", int'(bus.state), 1);
    chk("rst_restart_lives", int'(bus.lives), 3);
    clk_cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
